// File: rtl/rv_muldiv_unit.sv
// Multi-cycle RV64M/RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with a sign/word fix-up cycle.
module rv_muldiv_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;

  function automatic logic [XLEN-1:0] sx32(input logic [XLEN-1:0] x);
    return XLEN'($signed(x << (XLEN-32)) >>> (XLEN-32));
  endfunction

  function automatic logic [XLEN-1:0] zx32(input logic [XLEN-1:0] x);
    return (x << (XLEN-32)) >> (XLEN-32);
  endfunction

  logic [2:0]        op_q;
  logic              word_q, neg_a_q, neg_b_q;
  logic [XLEN-1:0]   a_q, b_q, quo_q, rem_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     cnt_q;
  logic [TAG_W-1:0]  tag_q;

  logic              word_eff, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_mag, special_raw, special_res;

  // Request decode: only MULW and the divide ops have W forms.
  always_comb begin
    word_eff = (XLEN == 64) && in_word && (in_op == 3'd0 || in_op[2]);
    a_signed = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
    b_signed = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
    a_ext    = word_eff ? (a_signed ? sx32(in_rs1) : zx32(in_rs1)) : in_rs1;
    b_ext    = word_eff ? (b_signed ? sx32(in_rs2) : zx32(in_rs2)) : in_rs2;
    a_neg    = a_signed && a_ext[XLEN-1];
    b_neg    = b_signed && b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    min_mag  = word_eff ? (XLEN'(1) << 31) : (XLEN'(1) << (XLEN-1));
    div_zero = in_op[2] && (b_ext == '0);
    div_ovf  = in_op[2] && !in_op[0] && a_neg && (a_mag == min_mag) && (b_ext == '1);
    special  = div_zero || div_ovf;
    if (in_op[1]) special_raw = div_zero ? a_ext : '0;
    else          special_raw = div_zero ? '1 : a_ext;
    special_res = word_eff ? sx32(special_raw) : special_raw;
  end

  assign in_ready  = (state_q == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (flush) state_d = IDLE; else if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = flush ? IDLE : DONE;
      DONE: if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [2*XLEN-1:0] acc_next, prod_s;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic [XLEN-1:0]   quo_s, rem_s, fix_raw, fix_res;

  // Restoring step: the sign bit of (partial - divisor) doubles as the borrow.
  always_comb begin
    acc_next  = {acc_q[2*XLEN-2:0], 1'b0} + (b_q[cnt_q] ? {{XLEN{1'b0}}, a_q} : '0);
    rem_shift = {rem_q, a_q[cnt_q]};
    rem_diff  = rem_shift - {1'b0, b_q};
    prod_s    = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_s     = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
    rem_s     = neg_a_q ? -rem_q : rem_q;
    case (op_q)
      3'd0:         fix_raw = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_raw = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:   fix_raw = quo_s;
      default:      fix_raw = rem_s;
    endcase
    fix_res = word_q ? sx32(fix_raw) : fix_raw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= '0; word_q <= 1'b0; neg_a_q <= 1'b0; neg_b_q <= 1'b0;
      a_q <= '0; b_q <= '0; quo_q <= '0; rem_q <= '0; acc_q <= '0;
      cnt_q <= '0; tag_q <= '0; out_result <= '0; out_tag <= '0;
    end else begin
      if (accept) begin
        op_q <= in_op; word_q <= word_eff; neg_a_q <= a_neg; neg_b_q <= b_neg;
        a_q <= a_mag; b_q <= b_mag; quo_q <= '0; rem_q <= '0; acc_q <= '0;
        cnt_q <= word_eff ? CW'(31) : CW'(XLEN-1);
        tag_q <= in_tag;
        if (special) begin
          out_result <= special_res;
          out_tag    <= in_tag;
        end
      end else if (state_q == CALC) begin
        acc_q <= acc_next;
        quo_q <= {quo_q[XLEN-2:0], !rem_diff[XLEN]};
        rem_q <= rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
        cnt_q <= cnt_q - 1'b1;
      end else if (state_q == FIX && !flush) begin
        out_result <= fix_res;
        out_tag    <= tag_q;
      end
    end
  end
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed bench for rv_muldiv_unit (XLEN=64): results, tags, latency,
// special-case divides, stall, flush and asynchronous reset.
module tb_rv_muldiv_unit;
  logic        clk, reset_n, flush, in_valid, in_word, out_ready;
  logic        in_ready, out_valid, busy;
  logic [2:0]  in_op;
  logic [63:0] in_rs1, in_rs2, out_result;
  logic [4:0]  in_tag, out_tag;
  int total = 0;
  int bad   = 0;
  int edges;
  int seen;

  rv_muldiv_unit #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its result; result left in DONE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] t,
                        input logic [63:0] exp_res, input int exp_lat);
    @(negedge clk);
    in_op = op; in_word = w; in_rs1 = a; in_rs2 = b; in_tag = t; in_valid = 1'b1;
    check({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, ".latency"}, edges, exp_lat);
    check({tag, ".result"}, out_result, exp_res);
    check({tag, ".tag"}, out_tag, t);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drop_valid"}, out_valid, 0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    #12;
    check("rst.out_valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.out_result", out_result, 0);
    check("rst.out_tag", out_tag, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst.in_ready", in_ready, 1);

    run_op("mul", 3'd0, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 5'd3, 64'hFFFFFFFFFFFFFFEB, 66);
    release_result("mul");
    run_op("mulhu", 3'd3, 1'b0, '1, '1, 5'd4, 64'hFFFFFFFFFFFFFFFE, 66);
    release_result("mulhu");
    run_op("mulhu_w", 3'd3, 1'b1, '1, '1, 5'd5, 64'hFFFFFFFFFFFFFFFE, 66);
    release_result("mulhu_w");
    run_op("mulh", 3'd1, 1'b0, '1, '1, 5'd6, 64'h0, 66);
    release_result("mulh");
    run_op("mulhsu", 3'd2, 1'b0, '1, 64'd2, 5'd7, 64'hFFFFFFFFFFFFFFFF, 66);
    release_result("mulhsu");
    run_op("mulw", 3'd0, 1'b1, 64'h7FFFFFFF, 64'd2, 5'd8, 64'hFFFFFFFFFFFFFFFE, 34);
    release_result("mulw");

    run_op("div0", 3'd4, 1'b0, 64'd5, 64'd0, 5'd10, 64'hFFFFFFFFFFFFFFFF, 1);
    release_result("div0");
    run_op("remu0", 3'd7, 1'b0, 64'd5, 64'd0, 5'd11, 64'd5, 1);
    release_result("remu0");
    run_op("divuw0", 3'd5, 1'b1, 64'h1_00000009, 64'd0, 5'd12, 64'hFFFFFFFFFFFFFFFF, 1);
    release_result("divuw0");
    run_op("div_ovf", 3'd4, 1'b0, 64'h8000000000000000, '1, 5'd13, 64'h8000000000000000, 1);
    release_result("div_ovf");
    run_op("rem_ovf", 3'd6, 1'b0, 64'h8000000000000000, '1, 5'd14, 64'h0, 1);
    release_result("rem_ovf");
    run_op("divw_ovf", 3'd4, 1'b1, 64'h80000000, 64'hFFFFFFFF, 5'd15, 64'hFFFFFFFF80000000, 1);
    release_result("divw_ovf");

    run_op("divw", 3'd4, 1'b1, 64'hFFFFFFF9, 64'd2, 5'd16, 64'hFFFFFFFFFFFFFFFD, 34);
    release_result("divw");
    run_op("remw", 3'd6, 1'b1, 64'hFFFFFFF9, 64'd2, 5'd17, 64'hFFFFFFFFFFFFFFFF, 34);
    release_result("remw");
    run_op("divuw", 3'd5, 1'b1, 64'hFFFFFFF0, 64'd2, 5'd18, 64'h000000007FFFFFF8, 34);
    release_result("divuw");
    run_op("div", 3'd4, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd19, 64'hFFFFFFFFFFFFFFFD, 66);
    release_result("div");
    run_op("remu", 3'd7, 1'b0, 64'd100, 64'd7, 5'd20, 64'd2, 66);
    release_result("remu");

    // Consumer stall in DONE.
    run_op("stall", 3'd0, 1'b0, 64'd3, 64'd4, 5'd9, 64'd12, 66);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall.result", out_result, 64'd12);
      check("stall.valid", out_valid, 1);
      check("stall.in_ready", in_ready, 0);
    end
    release_result("stall");

    // Flush in CALC, then confirm no result ever appears.
    @(negedge clk);
    in_op = 3'd5; in_word = 1'b0; in_rs1 = 64'd100; in_rs2 = 64'd7; in_tag = 5'd21; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("flush.busy_before", busy, 1);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    #1;
    check("flush.in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush.busy_after", busy, 0);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("flush.no_valid", seen, 0);
    check("flush.result_held", out_result, 64'd12);
    check("flush.tag_held", out_tag, 5'd9);

    // Flush with in_valid while idle must not accept.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle.busy", busy, 0);

    // Flush together with out_ready in DONE.
    run_op("flush_done", 3'd4, 1'b0, 64'd5, 64'd0, 5'd22, 64'hFFFFFFFFFFFFFFFF, 1);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done.valid", out_valid, 0);
    check("flush_done.busy", busy, 0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    in_op = 3'd0; in_word = 1'b0; in_rs1 = 64'd6; in_rs2 = 64'd7; in_tag = 5'd23; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("areset.busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check("areset.busy", busy, 0);
    check("areset.valid", out_valid, 0);
    check("areset.result", out_result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("after_reset", 3'd5, 1'b0, 64'd100, 64'd7, 5'd24, 64'd14, 66);
    release_result("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Multi-cycle RV64M/RV32M multiply/divide execution unit with valid/ready handshakes on both sides.
- Sits beside the single-cycle integer ALU in the execute stage and takes the M-extension opcodes.
- Implements correct unsigned and upper-half semantics, proper W-variant 32-bit sign extension, and the RISC-V divide-by-zero and overflow results.
- Parametrised in XLEN and tag width.

Parameters:
- XLEN, 64, datapath width (32 or 64); W variants are only legal when XLEN=64.
- TAG_W, 5, width of the pass-through destination tag (rd index).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of any in-flight or held operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_word  in  1  W variant (MULW/DIVW/DIVUW/REMW/REMUW).
- in_rs1  in  XLEN  operand 1.
- in_rs2  in  XLEN  operand 2.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, out_valid=0, out_result=0, out_tag=0, busy=0.
  - in_ready=1 once reset_n is released.
  - Reset mid-operation discards the operation.
- States: IDLE, CALC, FIX, DONE.
- in_ready = (state==IDLE) && !flush.
- Accept occurs on an edge with in_valid && in_ready; operands, op, word and tag are registered.
- IDLE -> CALC on a normal accept.
- IDLE -> DONE directly on a special-case divide. The result is valid 1 edge after accept.
  - Divide by zero (rs2==0): DIV/DIVU quotient = all ones; REM/REMU remainder = rs1 (word-extended for W ops).
  - Signed overflow (DIV/REM, rs1 = most-negative, rs2 = -1): quotient = rs1; remainder = 0.
- Word ops:
  - Operands are the low 32 bits, sign-extended (signed ops) or zero-extended (unsigned ops).
  - Iteration count N=32.
  - The result is the low 32 bits sign-extended to XLEN. This applies to DIVUW/REMUW too.
  - in_word with MULH/MULHSU/MULHU is treated as in_word=0.
- Non-word ops: N=XLEN.
- CALC: one radix-2 step per cycle on operand magnitudes, counter N-1 down to 0.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Leaves to FIX when counter==0.
- FIX (1 cycle): conditional negation.
  - Product negated if the operand signs differ (MULHSU treats rs2 as unsigned).
  - Quotient negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Select the low half (MUL), high half (MULH*), quotient or remainder.
  - Apply W extension.
  - -> DONE.
- Normal latency: out_valid rises exactly N+2 edges after the accept edge (66 for XLEN=64 non-W, 34 for W).
- DONE:
  - out_valid=1; out_result and out_tag are stable until out_ready=1.
  - On an edge with out_ready: -> IDLE, out_valid=0.
  - No new accept is possible in the same cycle (in_ready is low in DONE).
- flush:
  - Any state -> IDLE on the next edge; out_valid=0.
  - flush with in_valid in IDLE: not accepted.
  - flush with out_ready in DONE: result discarded, counts as no transfer.
- out_result and out_tag hold their last values when out_valid=0.
- There is no queueing; at most one operation is in flight.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFFFFFFFFFD), out_ready=1 -> out_result=0xFFFFFFFFFFFFFFEB, out_tag echoed, out_valid exactly 66 edges after accept.
- MULHU rs1=rs2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE. MULH with the same operands -> 0. MULHSU rs1=-1, rs2=2 -> 0xFFFFFFFFFFFFFFFF.
- Divide by zero, each with out_valid 1 edge after accept:
  - DIV 5/0 -> 0xFFFFFFFFFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIVUW rs1=0x1_00000009, rs2=0 -> 0xFFFFFFFFFFFFFFFF.
- Overflow: DIV 0x8000000000000000 / -1 -> 0x8000000000000000; REM with the same operands -> 0; DIVW 0x80000000 / 0xFFFFFFFF -> 0xFFFFFFFF80000000.
- Word ops (latency 34):
  - DIVW rs1=0x00000000FFFFFFF9, rs2=2 -> 0xFFFFFFFFFFFFFFFD.
  - REMW with the same operands -> 0xFFFFFFFFFFFFFFFF.
  - DIVUW 0xFFFFFFF0 / 2 -> 0x000000007FFFFFF8.
- Control:
  - out_ready low for 10 cycles in DONE -> out_result stable and in_ready=0.
  - flush at CALC cycle 20 -> IDLE next edge, no out_valid.
  - reset_n low mid-CALC -> out_valid=0 and busy=0 asynchronously; the next request completes correctly.
